// File: rtl/fetch_unit.sv
// fetch_unit: program counter, start/run/halt sequencing and loadable jump-target table.
// Ports: Clk/Reset (sync, active-low); Start/StartAddr launch a run from IDLE or DONE;
// Stall holds the PC; Halt ends the run; jump_en, branch_en+ZERO select table[TargetIdx];
// LutWe/LutWAddr/LutWData load the target table; ProgCtr addresses the ROM;
// Running/Done report state; CycleCount is a saturating count of RUN cycles.
module fetch_unit #(
  parameter int PC_W   = 10,
  parameter int LUT_AW = 5,
  parameter int CNT_W  = 16
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Start,
  input  logic [PC_W-1:0]   StartAddr,
  input  logic              Stall,
  input  logic              Halt,
  input  logic              jump_en,
  input  logic              branch_en,
  input  logic              ZERO,
  input  logic [LUT_AW-1:0] TargetIdx,
  input  logic              LutWe,
  input  logic [LUT_AW-1:0] LutWAddr,
  input  logic [PC_W-1:0]   LutWData,
  output logic [PC_W-1:0]   ProgCtr,
  output logic              Running,
  output logic              Done,
  output logic [CNT_W-1:0]  CycleCount
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t             r_state, w_state;
  logic [PC_W-1:0]    r_pc, w_pc;
  logic [CNT_W-1:0]   r_cnt, w_cnt;
  logic [PC_W-1:0]    r_lut [2**LUT_AW];
  logic               w_taken;
  assign w_taken    = jump_en | (branch_en & ZERO);
  assign ProgCtr    = r_pc;
  assign Running    = r_state == RUN;
  assign Done       = r_state == DONE;
  assign CycleCount = r_cnt;
  always_comb begin
    w_state = r_state;
    w_pc    = r_pc;
    w_cnt   = r_cnt;
    case (r_state)
      RUN: begin
        w_cnt = &r_cnt ? r_cnt : r_cnt + 1'b1;
        if (!Stall) begin
          if (Halt) w_state = DONE;
          else w_pc = w_taken ? r_lut[TargetIdx] : r_pc + 1'b1;
        end
      end
      default: if (Start) begin
        w_state = RUN;
        w_pc    = StartAddr;
        w_cnt   = '0;
      end
    endcase
  end
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      r_state <= IDLE;
      r_pc    <= '0;
      r_cnt   <= '0;
      for (int i = 0; i < 2**LUT_AW; i++) r_lut[i] <= '0;
    end else begin
      r_state <= w_state;
      r_pc    <= w_pc;
      r_cnt   <= w_cnt;
      if (LutWe) r_lut[LutWAddr] <= LutWData;
    end
  end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed scoreboard bench for fetch_unit.
module tb_fetch_unit;
  logic        clk = 0;
  logic        rst_n, start, stall, halt, jmp, br, zero, lut_we;
  logic [9:0]  start_addr, lut_wdata;
  logic [4:0]  tidx, lut_waddr;
  logic [9:0]  pc;
  logic        running, done;
  logic [15:0] cnt;
  int passed = 0, total = 0;
  typedef struct {
    string       nm;
    logic [9:0]  pc;
    logic        run;
    logic        done;
    logic [15:0] cnt;
  } exp_t;
  exp_t q[$];
  fetch_unit dut (
    .Clk(clk), .Reset(rst_n), .Start(start), .StartAddr(start_addr), .Stall(stall),
    .Halt(halt), .jump_en(jmp), .branch_en(br), .ZERO(zero), .TargetIdx(tidx),
    .LutWe(lut_we), .LutWAddr(lut_waddr), .LutWData(lut_wdata),
    .ProgCtr(pc), .Running(running), .Done(done), .CycleCount(cnt)
  );
  always #5 clk = ~clk;
  initial forever begin
    @(posedge clk);
    #1;
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      total++;
      if (pc === e.pc && running === e.run && done === e.done && cnt === e.cnt) passed++;
      else $display("FAIL %s: got pc=%h run=%b done=%b cnt=%h, required pc=%h run=%b done=%b cnt=%h",
                    e.nm, pc, running, done, cnt, e.pc, e.run, e.done, e.cnt);
    end
  end
  task automatic tick(input bit chk, input string nm, input logic [9:0] epc,
                      input logic erun, input logic edone, input logic [15:0] ecnt);
    exp_t e;
    if (chk) begin
      e.nm = nm; e.pc = epc; e.run = erun; e.done = edone; e.cnt = ecnt;
      q.push_back(e);
    end
    @(posedge clk);
    #2;
  endtask
  task automatic wait_done(input int budget);
    int n = 0;
    while (!done && n < budget) begin
      @(posedge clk);
      #2;
      n++;
    end
    total++;
    if (done === 1'b1) passed++;
    else $display("FAIL wait_done: Done=%b after %0d cycles, required 1", done, n);
  endtask
  initial begin
    rst_n = 0; start = 0; stall = 0; halt = 0; jmp = 0; br = 0; zero = 0; lut_we = 0;
    start_addr = 0; lut_wdata = 0; tidx = 0; lut_waddr = 0;
    tick(1, "reset", 10'h000, 0, 0, 16'h0);
    rst_n = 1;
    tick(1, "idle_hold", 10'h000, 0, 0, 16'h0);
    start = 1; start_addr = 10'h005;
    tick(1, "start5", 10'h005, 1, 0, 16'd0);
    start = 0;
    tick(1, "inc6", 10'h006, 1, 0, 16'd1);
    tick(1, "inc7", 10'h007, 1, 0, 16'd2);
    tick(1, "inc8", 10'h008, 1, 0, 16'd3);
    tick(1, "inc9", 10'h009, 1, 0, 16'd4);
    halt = 1;
    tick(1, "halt9", 10'h009, 0, 1, 16'd5);
    halt = 0;
    tick(1, "done_hold", 10'h009, 0, 1, 16'd5);
    lut_we = 1; lut_waddr = 3; lut_wdata = 10'h120;
    tick(1, "lut_wr_done", 10'h009, 0, 1, 16'd5);
    lut_we = 0; start = 1; start_addr = 10'h040;
    tick(1, "start40", 10'h040, 1, 0, 16'd0);
    start = 0; br = 1; tidx = 3; zero = 0;
    tick(1, "br_nt", 10'h041, 1, 0, 16'd1);
    zero = 1;
    tick(1, "br_t", 10'h120, 1, 0, 16'd2);
    br = 0; zero = 0; jmp = 1;
    tick(1, "jmp3", 10'h120, 1, 0, 16'd3);
    br = 1; tidx = 0;
    tick(1, "jmp_br_both", 10'h000, 1, 0, 16'd4);
    halt = 1; tidx = 3;
    tick(1, "halt_over_jmp", 10'h000, 0, 1, 16'd5);
    halt = 0; jmp = 0; br = 0; start = 1; start_addr = 10'h3FF;
    tick(1, "start3ff", 10'h3FF, 1, 0, 16'd0);
    start = 0;
    tick(1, "wrap", 10'h000, 1, 0, 16'd1);
    stall = 1; halt = 1;
    tick(1, "stall1", 10'h000, 1, 0, 16'd2);
    tick(1, "stall2", 10'h000, 1, 0, 16'd3);
    stall = 0;
    tick(1, "halt_after_stall", 10'h000, 0, 1, 16'd4);
    halt = 0; lut_we = 1; lut_waddr = 7; lut_wdata = 10'h011;
    tick(0, "", 0, 0, 0, 0);
    lut_we = 0; start = 1; start_addr = 10'h100;
    tick(1, "start100", 10'h100, 1, 0, 16'd0);
    start = 0; lut_we = 1; lut_waddr = 7; lut_wdata = 10'h0AA; jmp = 1; tidx = 7;
    tick(1, "wr_jmp_old", 10'h011, 1, 0, 16'd1);
    lut_we = 0;
    tick(1, "jmp_new", 10'h0AA, 1, 0, 16'd2);
    jmp = 0; halt = 1;
    tick(0, "", 0, 0, 0, 0);
    halt = 0; start = 1; start_addr = 10'h04E;
    tick(0, "", 0, 0, 0, 0);
    start = 0;
    tick(0, "", 0, 0, 0, 0);
    tick(1, "pc50", 10'h050, 1, 0, 16'd2);
    start = 1; start_addr = 10'h200;
    tick(1, "start_in_run", 10'h051, 1, 0, 16'd3);
    start = 0; rst_n = 0;
    tick(1, "mid_reset", 10'h000, 0, 0, 16'd0);
    rst_n = 1; start = 1; start_addr = 10'h010;
    tick(1, "start10", 10'h010, 1, 0, 16'd0);
    start = 0; jmp = 1; tidx = 7;
    tick(1, "lut7_cleared", 10'h000, 1, 0, 16'd1);
    tidx = 3;
    tick(1, "lut3_cleared", 10'h000, 1, 0, 16'd2);
    jmp = 0; halt = 1;
    tick(0, "", 0, 0, 0, 0);
    halt = 0; start = 1; start_addr = 10'h000;
    tick(1, "start_long", 10'h000, 1, 0, 16'd0);
    start = 0;
    for (int i = 0; i < 65539; i++) tick(0, "", 0, 0, 0, 0);
    tick(1, "saturate", 10'h004, 1, 0, 16'hFFFF);
    halt = 1;
    wait_done(4);
    halt = 0;
    tick(1, "sat_done_hold", 10'h004, 0, 1, 16'hFFFF);
    start = 1; start_addr = 10'h123;
    tick(1, "restart_clr", 10'h123, 1, 0, 16'd0);
    start = 0;
    tick(1, "restart_inc", 10'h124, 1, 0, 16'd1);
    #5;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
